// File: rtl/revaluate_param.sv
// Iterative chi-step unit: applies the 5-cell row nonlinearity to a 5x5xLANE_W state,
// ROWS_PER_CYCLE rows per clock. Optional abort input enabled by macro REVALUATE_ABORT_EN.
module revaluate_param #(
   parameter int unsigned LANE_W         = 64,
   parameter int unsigned ROWS_PER_CYCLE = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
`ifdef REVALUATE_ABORT_EN
   input  logic                 abort,
`endif
   input  logic [25*LANE_W-1:0] data_in,
   output logic                 busy,
   output logic                 done,
   output logic [25*LANE_W-1:0] data_out
);

   localparam int unsigned NUM_CELLS = 25 * LANE_W;
   localparam int unsigned NUM_ROWS  = 5 * LANE_W;
   localparam int unsigned CNT_W     = $clog2(NUM_ROWS + 1);
   localparam int unsigned LAST_ROW  = NUM_ROWS - ROWS_PER_CYCLE;

   // Reject illegal configurations at elaboration
   generate
      if (LANE_W < 1 || LANE_W > 64) begin : g_bad_lane
         $error("revaluate_param: LANE_W must be in 1..64");
      end
      if (ROWS_PER_CYCLE == 0) begin : g_zero_rpc
         $error("revaluate_param: ROWS_PER_CYCLE must be nonzero");
      end else if ((NUM_ROWS % ROWS_PER_CYCLE) != 0) begin : g_bad_rpc
         $error("revaluate_param: ROWS_PER_CYCLE must divide 5*LANE_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_CELLS-1:0] work_q;
   logic [NUM_CELLS-1:0] chi_c;
   logic [NUM_CELLS-1:0] next_work_c;
   logic [NUM_ROWS-1:0]  row_sel_c;
   logic                 abort_c;

`ifdef REVALUATE_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // Rows are processed in aligned groups, so each row matches exactly one counter value
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row_sel
      assign row_sel_c[r] = (cnt_q == CNT_W'((r / ROWS_PER_CYCLE) * ROWS_PER_CYCLE));
   end

   // Chi only mixes cells within a row, so in-place group updates give the full result
   for (genvar y = 0; y < 5; y++) begin : g_y
      for (genvar x = 0; x < 5; x++) begin : g_x
         for (genvar z = 0; z < LANE_W; z++) begin : g_z
            localparam int unsigned B0 = LANE_W * (5 * y + x) + z;
            localparam int unsigned B1 = LANE_W * (5 * y + (x + 1) % 5) + z;
            localparam int unsigned B2 = LANE_W * (5 * y + (x + 2) % 5) + z;
            localparam int unsigned R  = y * LANE_W + z;
            assign chi_c[B0]       = work_q[B0] ^ (~work_q[B1] & work_q[B2]);
            assign next_work_c[B0] = row_sel_c[R] ? chi_c[B0] : work_q[B0];
         end
      end
   end

   // Control FSM with registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  work_q  <= data_in;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= ST_PROC;
               end
            end
            ST_PROC: begin
               if (abort_c) begin
                  work_q  <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  work_q <= next_work_c;
                  if (cnt_q == CNT_W'(LAST_ROW)) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(ROWS_PER_CYCLE);
                  end
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_out = work_q;

endmodule

// File: tb/tb_revaluate_param.sv
// Directed bench for revaluate_param over four configurations; define REVALUATE_ABORT_EN
// to include the abort scenario.
module tb_revaluate_param;

   logic clk;
   logic rst;

   logic          start0, start1, start2, start3;
   logic          busy0, busy1, busy2, busy3;
   logic          done0, done1, done2, done3;
   logic [24:0]   din0, dout0;
   logic [1599:0] din1, din2, din3, dout1, dout2, dout3;
`ifdef REVALUATE_ABORT_EN
   logic          abort0;
`endif

   int n_checks;
   int n_fail;

   revaluate_param #(.LANE_W(1), .ROWS_PER_CYCLE(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
`ifdef REVALUATE_ABORT_EN
      .abort(abort0),
`endif
      .data_in(din0), .busy(busy0), .done(done0), .data_out(dout0));

   revaluate_param #(.LANE_W(64), .ROWS_PER_CYCLE(5)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
`ifdef REVALUATE_ABORT_EN
      .abort(1'b0),
`endif
      .data_in(din1), .busy(busy1), .done(done1), .data_out(dout1));

   revaluate_param #(.LANE_W(64), .ROWS_PER_CYCLE(1)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
`ifdef REVALUATE_ABORT_EN
      .abort(1'b0),
`endif
      .data_in(din2), .busy(busy2), .done(done2), .data_out(dout2));

   revaluate_param #(.LANE_W(64), .ROWS_PER_CYCLE(320)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
`ifdef REVALUATE_ABORT_EN
      .abort(1'b0),
`endif
      .data_in(din3), .busy(busy3), .done(done3), .data_out(dout3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference chi transform written straight from the cell formula
   function automatic logic [1599:0] chi_ref(input logic [1599:0] a, input int lw);
      logic [1599:0] o;
      o = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            for (int z = 0; z < lw; z++)
               o[lw*(5*y+x)+z] = a[lw*(5*y+x)+z] ^
                                 (~a[lw*(5*y+(x+1)%5)+z] & a[lw*(5*y+(x+2)%5)+z]);
      return o;
   endfunction

   function automatic logic get_busy(input int d);
      case (d)
         0: return busy0;
         1: return busy1;
         2: return busy2;
         default: return busy3;
      endcase
   endfunction

   function automatic logic get_done(input int d);
      case (d)
         0: return done0;
         1: return done1;
         2: return done2;
         default: return done3;
      endcase
   endfunction

   function automatic logic [1599:0] get_dout(input int d);
      case (d)
         0: return 1600'(dout0);
         1: return dout1;
         2: return dout2;
         default: return dout3;
      endcase
   endfunction

   task automatic set_start(input int d, input logic v);
      case (d)
         0: start0 = v;
         1: start1 = v;
         2: start2 = v;
         default: start3 = v;
      endcase
   endtask

   task automatic set_din(input int d, input logic [1599:0] v);
      case (d)
         0: din0 = v[24:0];
         1: din1 = v;
         2: din2 = v;
         default: din3 = v;
      endcase
   endtask

   // One start pulse; counts edges from the capturing edge (edge 1) to the done sample
   task automatic run_op(input int d, input logic [1599:0] din, output int edges,
                         output int busy_cycles, output logic [1599:0] res);
      @(posedge clk); #1;
      set_din(d, din);
      set_start(d, 1'b1);
      @(posedge clk); #1;
      set_start(d, 1'b0);
      set_din(d, ~din);
      edges = 1;
      busy_cycles = 0;
      while (get_done(d) !== 1'b1 && edges < 400) begin
         if (get_busy(d) === 1'b1) busy_cycles++;
         @(posedge clk); #1;
         edges++;
      end
      res = get_dout(d);
   endtask

   function automatic logic [1599:0] rand_state();
      logic [1599:0] v;
      for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic test_reset();
      int e;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         n_checks++;
         if (get_busy(d) !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy dut%0d: got %b expected 0", d, get_busy(d));
         end
         n_checks++;
         if (get_done(d) !== 1'b0) begin
            n_fail++; $display("FAIL reset_done dut%0d: got %b expected 0", d, get_done(d));
         end
         n_checks++;
         if (get_dout(d) !== '0) begin
            n_fail++; $display("FAIL reset_dout dut%0d: got %h expected 0", d, get_dout(d)[127:0]);
         end
      end
      rst = 1'b1;
      din0 = 25'h0000004;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++; $display("FAIL first_start_busy: got %b expected 1", busy0);
      end
      e = 1;
      while (done0 !== 1'b1 && e < 40) begin
         @(posedge clk); #1;
         e++;
      end
      n_checks++;
      if (e !== 6 || dout0 !== 25'h0000005) begin
         n_fail++; $display("FAIL first_start_result: got edges %0d data %h expected edges 6 data 0000005", e, dout0);
      end
   endtask

   task automatic test_small_vectors();
      logic [24:0]   vin[6];
      logic [24:0]   vexp[6];
      logic [1599:0] res;
      int edges, bc;
      vin[0] = 25'h0000004; vexp[0] = 25'h0000005;
      vin[1] = 25'h0000001; vexp[1] = 25'h0000009;
      vin[2] = 25'h0000003; vexp[2] = 25'h000000B;
      vin[3] = 25'h0000080; vexp[3] = 25'h00000A0;
      vin[4] = 25'h1FFFFFF; vexp[4] = 25'h1FFFFFF;
      vin[5] = 25'h0000000; vexp[5] = 25'h0000000;
      for (int i = 0; i < 6; i++) begin
         run_op(0, 1600'(vin[i]), edges, bc, res);
         n_checks++;
         if (edges !== 6) begin
            n_fail++; $display("FAIL small_latency[%0d]: got %0d edges expected 6", i, edges);
         end
         n_checks++;
         if (res[24:0] !== vexp[i]) begin
            n_fail++; $display("FAIL small_data[%0d]: got %h expected %h", i, res[24:0], vexp[i]);
         end
      end
   endtask

   task automatic test_wide();
      int            exp_edges[3];
      logic [1599:0] v, exp_v, res;
      int            edges, bc;
      exp_edges[0] = 65; exp_edges[1] = 321; exp_edges[2] = 2;
      for (int d = 1; d < 4; d++) begin
         v = rand_state();
         exp_v = chi_ref(v, 64);
         run_op(d, v, edges, bc, res);
         n_checks++;
         if (edges !== exp_edges[d-1]) begin
            n_fail++; $display("FAIL wide_latency dut%0d: got %0d edges expected %0d", d, edges, exp_edges[d-1]);
         end
         n_checks++;
         if (bc !== exp_edges[d-1] - 1) begin
            n_fail++; $display("FAIL wide_busy dut%0d: got %0d cycles expected %0d", d, bc, exp_edges[d-1] - 1);
         end
         n_checks++;
         if (res !== exp_v) begin
            n_fail++; $display("FAIL wide_data dut%0d: got %h expected %h", d, res[127:0], exp_v[127:0]);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dout3 !== exp_v) begin
         n_fail++; $display("FAIL idle_hold: got %h expected %h", dout3[127:0], exp_v[127:0]);
      end
   endtask

   task automatic test_start_ignored();
      int          ndone, de;
      logic [24:0] r;
      ndone = 0; de = 0; r = '0;
      @(posedge clk); #1;
      din0 = 25'h0000001;
      start0 = 1'b1;
      @(posedge clk); #1;
      din0 = 25'h1FFFFFF;
      for (int e = 1; e <= 12; e++) begin
         if (e > 1) begin
            @(posedge clk); #1;
         end
         start0 = busy0;
         if (done0 === 1'b1) begin
            ndone++; de = e; r = dout0;
         end
      end
      start0 = 1'b0;
      n_checks++;
      if (ndone !== 1 || de !== 6) begin
         n_fail++; $display("FAIL start_ignored_done: got %0d pulses at edge %0d expected 1 at edge 6", ndone, de);
      end
      n_checks++;
      if (r !== 25'h0000009) begin
         n_fail++; $display("FAIL start_ignored_data: got %h expected 0000009", r);
      end
   endtask

   task automatic test_back_to_back();
      int          ndone, e1, e2;
      logic [24:0] r1, r2;
      ndone = 0; e1 = 0; e2 = 0; r1 = '0; r2 = '0;
      @(posedge clk); #1;
      din0 = 25'h0000004;
      start0 = 1'b1;
      @(posedge clk); #1;
      din0 = 25'h0000080;
      for (int e = 1; e <= 14; e++) begin
         if (e > 1) begin
            @(posedge clk); #1;
         end
         if (e == 7) begin
            n_checks++;
            if (busy0 !== 1'b0 || done0 !== 1'b0) begin
               n_fail++; $display("FAIL b2b_idle_gap: got busy %b done %b expected 0 0", busy0, done0);
            end
         end
         if (done0 === 1'b1) begin
            ndone++;
            if (ndone == 1) begin e1 = e; r1 = dout0; end
            else begin e2 = e; r2 = dout0; end
         end
      end
      start0 = 1'b0;
      n_checks++;
      if (ndone !== 2 || e1 !== 6 || e2 !== 13) begin
         n_fail++; $display("FAIL b2b_timing: got %0d pulses at %0d,%0d expected 2 at 6,13", ndone, e1, e2);
      end
      n_checks++;
      if (r1 !== 25'h0000005 || r2 !== 25'h00000A0) begin
         n_fail++; $display("FAIL b2b_data: got %h,%h expected 0000005,00000a0", r1, r2);
      end
   endtask

   task automatic test_reset_mid();
      logic [1599:0] v, res;
      int            edges, bc, dcount;
      v = rand_state();
      @(posedge clk); #1;
      din2 = v;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      din2 = ~v;
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (busy2 !== 1'b1) begin
         n_fail++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy2);
      end
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0 || dout2 !== '0) begin
         n_fail++; $display("FAIL mid_reset_async: got busy %b done %b data %h expected 0 0 0", busy2, done2, dout2[127:0]);
      end
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      dcount = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done2 === 1'b1) dcount++;
      end
      n_checks++;
      if (dcount !== 0) begin
         n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", dcount);
      end
      v = rand_state();
      run_op(2, v, edges, bc, res);
      n_checks++;
      if (edges !== 321 || res !== chi_ref(v, 64)) begin
         n_fail++; $display("FAIL mid_recover: got edges %0d data %h expected edges 321 data %h", edges, res[127:0], chi_ref(v, 64) ^ 1600'(0));
      end
   endtask

`ifdef REVALUATE_ABORT_EN
   task automatic test_abort();
      int            dcount, edges, bc;
      logic [1599:0] res;
      @(posedge clk); #1;
      din0 = 25'h0000004;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy0);
      end
      abort0 = 1'b1;
      @(posedge clk); #1;
      abort0 = 1'b0;
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || dout0 !== '0) begin
         n_fail++; $display("FAIL abort_idle: got busy %b done %b data %h expected 0 0 0", busy0, done0, dout0);
      end
      dcount = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done0 === 1'b1) dcount++;
      end
      n_checks++;
      if (dcount !== 0) begin
         n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcount);
      end
      run_op(0, 1600'(25'h0000001), edges, bc, res);
      n_checks++;
      if (edges !== 6 || res[24:0] !== 25'h0000009) begin
         n_fail++; $display("FAIL abort_recover: got edges %0d data %h expected edges 6 data 0000009", edges, res[24:0]);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
`ifdef REVALUATE_ABORT_EN
      abort0 = 1'b0;
`endif
      test_reset();
      test_small_vectors();
      test_wide();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
`ifdef REVALUATE_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
